// File: rtl/uop_nxor_core_if.sv
// Operand/result bundle for the XNOR equivalence unit.
// The master drives the operands and the slave returns the results.
interface uop_nxor_core_if #(
    parameter int unsigned WIDTH = 1
);
    localparam int unsigned CNT_W = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);

    logic              in_valid;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [WIDTH-1:0]  y;
    logic              out_valid;
    logic [WIDTH-1:0]  y_q;
    logic              eq_q;
    logic [CNT_W-1:0]  match_cnt_q;

    modport master (
        output in_valid, a, b,
        input  y, out_valid, y_q, eq_q, match_cnt_q
    );

    modport slave (
        input  in_valid, a, b,
        output y, out_valid, y_q, eq_q, match_cnt_q
    );
endinterface

// File: rtl/uop_nxor_core.sv
// Bitwise XNOR unit: combinational y plus a one-cycle registered result
// with an all-equal flag and a count of matching bit positions.
module uop_nxor_core #(
    parameter int unsigned WIDTH = 1
) (
    input logic            clk,
    input logic            rst_n,
    uop_nxor_core_if.slave bus
);
    localparam int unsigned CNT_W = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);

    logic [WIDTH-1:0] eqv;
    logic [CNT_W-1:0] cnt;

    assign eqv   = ~(bus.a ^ bus.b);
    assign bus.y = eqv;

    // Population count of matching bit positions.
    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt = cnt + CNT_W'(eqv[i]);
        end
    end

    // Result registers hold their value while in_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid   <= 1'b0;
            bus.y_q         <= '0;
            bus.eq_q        <= 1'b0;
            bus.match_cnt_q <= '0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.y_q         <= eqv;
                bus.eq_q        <= &eqv;
                bus.match_cnt_q <= cnt;
            end
        end
    end
endmodule

// File: tb/tb_uop_nxor_core.sv
// Self-checking bench for uop_nxor_core at WIDTH=1 and WIDTH=8.
// Expected results are queued at drive time and popped when out_valid shows.
`timescale 1ns/1ps
module tb_uop_nxor_core;
    typedef struct {
        logic [7:0] y;
        logic       eq;
        logic [3:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t q1[$];
    exp_t q8[$];
    exp_t last8;

    uop_nxor_core_if #(.WIDTH(1)) bus1();
    uop_nxor_core_if #(.WIDTH(8)) bus8();

    uop_nxor_core #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    uop_nxor_core #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: bit i matches when a[i] == b[i]; equal when all w bits match.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int w);
        exp_t e;
        e.y   = 8'h00;
        e.cnt = 4'd0;
        for (int i = 0; i < w; i++) begin
            if (a[i] == b[i]) begin
                e.y[i] = 1'b1;
                e.cnt  = e.cnt + 4'd1;
            end
        end
        e.eq = (int'(e.cnt) == w);
        return e;
    endfunction

    task automatic pop_check8(input string tag);
        exp_t e;
        checks++;
        if (q8.size() == 0) begin
            failures++;
            $display("FAIL %s w8 out_valid=%0b with empty scoreboard", tag, bus8.out_valid);
        end else begin
            e = q8.pop_front();
            if (bus8.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL %s w8 out_valid got=%0b exp=1", tag, bus8.out_valid);
            end
            checks++;
            if (bus8.y_q !== e.y) begin
                failures++;
                $display("FAIL %s w8 y_q got=%h exp=%h", tag, bus8.y_q, e.y);
            end
            checks++;
            if (bus8.eq_q !== e.eq) begin
                failures++;
                $display("FAIL %s w8 eq_q got=%0b exp=%0b", tag, bus8.eq_q, e.eq);
            end
            checks++;
            if (bus8.match_cnt_q !== e.cnt) begin
                failures++;
                $display("FAIL %s w8 match_cnt_q got=%0d exp=%0d", tag, bus8.match_cnt_q, e.cnt);
            end
            last8 = e;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0;
        bus8.in_valid = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00;
        #3;
        checks++;
        if ({bus1.out_valid, bus1.y_q, bus1.eq_q, bus1.match_cnt_q} !== 4'b0000) begin
            failures++;
            $display("FAIL reset w1 outputs got=%b exp=0000",
                     {bus1.out_valid, bus1.y_q, bus1.eq_q, bus1.match_cnt_q});
        end
        checks++;
        if (bus8.out_valid !== 1'b0 || bus8.y_q !== 8'h00 || bus8.eq_q !== 1'b0 ||
            bus8.match_cnt_q !== 4'd0) begin
            failures++;
            $display("FAIL reset w8 outputs got ov=%0b y_q=%h eq=%0b cnt=%0d exp all 0",
                     bus8.out_valid, bus8.y_q, bus8.eq_q, bus8.match_cnt_q);
        end
        checks++;
        if (bus8.y !== 8'hFF) begin
            failures++;
            $display("FAIL reset_comb w8 y got=%h exp=ff", bus8.y);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_comb_sweep();
        logic [1:0] ab;
        logic [7:0] va [4];
        logic [7:0] vb [4];
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            bus1.a = ab[1];
            bus1.b = ab[0];
            #0.05;
            e = model({7'd0, ab[1]}, {7'd0, ab[0]}, 1);
            checks++;
            if (bus1.y !== e.y[0]) begin
                failures++;
                $display("FAIL comb_w1 ab=%b y got=%b exp=%b", ab, bus1.y, e.y[0]);
            end
        end
        va[0] = 8'hF0; vb[0] = 8'hFF;
        va[1] = 8'h00; vb[1] = 8'hFF;
        va[2] = 8'hA5; vb[2] = 8'hA5;
        va[3] = 8'h3C; vb[3] = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            bus8.a = va[i];
            bus8.b = vb[i];
            #0.05;
            e = model(va[i], vb[i], 8);
            checks++;
            if (bus8.y !== e.y) begin
                failures++;
                $display("FAIL comb_w8 a=%h b=%h y got=%h exp=%h", va[i], vb[i], bus8.y, e.y);
            end
        end
    endtask

    task automatic test_w1_pipe();
        exp_t e;
        logic [1:0] ab;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ab = 2'(i);
            bus1.in_valid = 1'b1;
            bus1.a = ab[1];
            bus1.b = ab[0];
            q1.push_back(model({7'd0, ab[1]}, {7'd0, ab[0]}, 1));
            @(posedge clk); #1;
            checks++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL pipe_w1 out_valid=%0b with empty scoreboard", bus1.out_valid);
            end else begin
                e = q1.pop_front();
                if (bus1.out_valid !== 1'b1 || bus1.y_q !== e.y[0] || bus1.eq_q !== e.eq ||
                    bus1.match_cnt_q !== e.cnt[0]) begin
                    failures++;
                    $display("FAIL pipe_w1 ab=%b got ov=%0b y_q=%0b eq=%0b cnt=%0d exp ov=1 y_q=%0b eq=%0b cnt=%0d",
                             ab, bus1.out_valid, bus1.y_q, bus1.eq_q, bus1.match_cnt_q,
                             e.y[0], e.eq, e.cnt[0]);
                end
            end
        end
        @(negedge clk);
        bus1.in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus1.out_valid !== 1'b0 || bus1.y_q !== 1'b1) begin
            failures++;
            $display("FAIL hold_w1 got ov=%0b y_q=%0b exp ov=0 y_q=1", bus1.out_valid, bus1.y_q);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [7];
        logic [7:0] vb [7];
        va[0] = 8'hF0; vb[0] = 8'hFF;
        va[1] = 8'hA5; vb[1] = 8'hA5;
        va[2] = 8'h00; vb[2] = 8'hFF;
        for (int i = 3; i < 7; i++) begin
            va[i] = 8'($urandom_range(0, 255));
            vb[i] = 8'($urandom_range(0, 255));
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus8.in_valid = 1'b1;
            bus8.a = va[i];
            bus8.b = vb[i];
            q8.push_back(model(va[i], vb[i], 8));
            @(posedge clk); #1;
            pop_check8("b2b");
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        bus8.in_valid = 1'b0;
        bus8.a = 8'h12;
        bus8.b = 8'h34;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus8.out_valid !== 1'b0 || bus8.y_q !== last8.y || bus8.eq_q !== last8.eq ||
                bus8.match_cnt_q !== last8.cnt) begin
                failures++;
                $display("FAIL hold_w8 got ov=%0b y_q=%h eq=%0b cnt=%0d exp ov=0 y_q=%h eq=%0b cnt=%0d",
                         bus8.out_valid, bus8.y_q, bus8.eq_q, bus8.match_cnt_q,
                         last8.y, last8.eq, last8.cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus8.in_valid = 1'b1;
        bus8.a = 8'hC3;
        bus8.b = 8'hC3;
        q8.push_back(model(8'hC3, 8'hC3, 8));
        @(posedge clk); #1;
        pop_check8("pre_rst");
        #2;
        rst_n = 1'b0;
        bus8.in_valid = 1'b0;
        #0.5;
        checks++;
        if (bus8.out_valid !== 1'b0 || bus8.y_q !== 8'h00 || bus8.eq_q !== 1'b0 ||
            bus8.match_cnt_q !== 4'd0) begin
            failures++;
            $display("FAIL async_rst w8 got ov=%0b y_q=%h eq=%0b cnt=%0d exp all 0",
                     bus8.out_valid, bus8.y_q, bus8.eq_q, bus8.match_cnt_q);
        end
        bus8.a = 8'h3C;
        bus8.b = 8'h0F;
        #0.05;
        checks++;
        if (bus8.y !== 8'hCC) begin
            failures++;
            $display("FAIL rst_comb w8 y got=%h exp=cc", bus8.y);
        end
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus8.out_valid !== 1'b0 || bus8.y_q !== 8'h00) begin
            failures++;
            $display("FAIL post_rst w8 got ov=%0b y_q=%h exp ov=0 y_q=00", bus8.out_valid, bus8.y_q);
        end
        @(negedge clk);
        bus8.in_valid = 1'b1;
        q8.push_back(model(8'h3C, 8'h0F, 8));
        @(posedge clk); #1;
        pop_check8("post_rst_txn");
        @(negedge clk);
        bus8.in_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_comb_sweep();
        test_w1_pipe();
        test_back_to_back();
        test_hold();
        test_async_reset();
        checks++;
        if (q1.size() != 0 || q8.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left w1=%0d w8=%0d exp 0", q1.size(), q8.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
